// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control encodings: opcodes, function codes, ALU operations,
// datapath mux selects and the multi-cycle state encoding.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_SRL = 6'b000010;
   localparam logic [5:0] FN_SRA = 6'b000011;

   // ALU_FUNC tells the ALU to decode FuncCode itself (R-type).
   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_ADDU = 4'b0011;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SLTU = 4'b1000;
   localparam logic [3:0] ALU_XOR  = 4'b1001;
   localparam logic [3:0] ALU_LUI  = 4'b1010;
   localparam logic [3:0] ALU_FUNC = 4'b1111;

   localparam logic [1:0] SRC2_RT   = 2'd0;
   localparam logic [1:0] SRC2_IMM  = 2'd1;
   localparam logic [1:0] SRC2_FOUR = 2'd2;

   localparam logic [1:0] DST_RT = 2'd0;
   localparam logic [1:0] DST_RD = 2'd1;
   localparam logic [1:0] DST_RA = 2'd2;

   localparam logic [1:0] M2R_ALU = 2'd0;
   localparam logic [1:0] M2R_MEM = 2'd1;
   localparam logic [1:0] M2R_PC4 = 2'd2;

   localparam logic [1:0] PCS_PC4 = 2'd0;
   localparam logic [1:0] PCS_BR  = 2'd1;
   localparam logic [1:0] PCS_JMP = 2'd2;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_ERR    = 3'd5
   } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of the latched instruction fields into ALU operation,
// immediate extension, shamt select and opcode legality.
module alu_op_decode
   import mips_ctrl_pkg::*;
#(
   parameter int SUPPORT_JAL = 1
) (
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output logic [3:0] alu_op,
   output logic       sign_ext,
   output logic       alu_src1,
   output logic       legal
);

   always_comb begin
      alu_op   = ALU_ADD;
      sign_ext = 1'b0;
      alu_src1 = 1'b0;
      legal    = 1'b1;
      case (opcode)
         OP_RTYPE: begin
            alu_op   = ALU_FUNC;
            alu_src1 = (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA);
         end
         OP_LW, OP_SW, OP_ADDI: sign_ext = 1'b1;
         OP_ADDIU: begin alu_op = ALU_ADDU; sign_ext = 1'b1; end
         OP_SLTI:  begin alu_op = ALU_SLT;  sign_ext = 1'b1; end
         OP_SLTIU: begin alu_op = ALU_SLTU; sign_ext = 1'b1; end
         OP_BEQ:   begin alu_op = ALU_SUB;  sign_ext = 1'b1; end
         OP_ANDI:  alu_op = ALU_AND;
         OP_ORI:   alu_op = ALU_OR;
         OP_XORI:  alu_op = ALU_XOR;
         OP_LUI:   alu_op = ALU_LUI;
         OP_J:     legal = 1'b1;
         OP_JAL:   legal = (SUPPORT_JAL != 0);
         default:  legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control: FETCH/DECODE/EXEC/MEM/WB sequencer with a
// MemReady handshake, memory wait timeout and illegal-opcode trap.
module multi_cycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int ALUOP_W     = 4,
   parameter int MEM_TIMEOUT = 15,
   parameter int SUPPORT_JAL = 1
) (
   input  logic               CLK,
   input  logic               Reset_L,
   input  logic [5:0]         Opcode,
   input  logic [5:0]         FuncCode,
   input  logic               MemReady,
   input  logic               Zero,
   output logic               PCWrite,
   output logic               IRWrite,
   output logic               MemRead,
   output logic               MemWrite,
   output logic               RegWrite,
   output logic [1:0]         RegDst,
   output logic               ALUSrc1,
   output logic [1:0]         ALUSrc2,
   output logic [1:0]         MemToReg,
   output logic [1:0]         PCSource,
   output logic               SignExtend,
   output logic               IorD,
   output logic [ALUOP_W-1:0] ALUOp,
   output logic               Illegal,
   output logic               MemError,
   output logic [2:0]         State
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic [5:0]       op_q;
   logic [5:0]       funct_q;

   logic [3:0]         dec_alu;
   logic               dec_sext;
   logic               dec_src1;
   logic               legal;
   logic [ALUOP_W-1:0] dec_alu_ext;
   logic               is_rtype, is_j, is_jal, is_beq, is_lw, is_sw;
   logic               waiting, timeout;

   alu_op_decode #(.SUPPORT_JAL(SUPPORT_JAL)) u_dec (
      .opcode   (op_q),
      .funct    (funct_q),
      .alu_op   (dec_alu),
      .sign_ext (dec_sext),
      .alu_src1 (dec_src1),
      .legal    (legal)
   );

   assign is_rtype    = (op_q == OP_RTYPE);
   assign is_j        = (op_q == OP_J);
   assign is_jal      = (op_q == OP_JAL);
   assign is_beq      = (op_q == OP_BEQ);
   assign is_lw       = (op_q == OP_LW);
   assign is_sw       = (op_q == OP_SW);
   assign dec_alu_ext = (dec_alu == ALU_FUNC) ? '1 : ALUOP_W'(dec_alu);
   assign waiting     = (state == S_FETCH) || (state == S_MEM);
   // A MemReady arriving on the last allowed wait cycle still completes.
   assign timeout     = waiting && !MemReady && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));
   assign State       = state;

   always_ff @(posedge CLK) begin
      if (!Reset_L) begin
         state    <= S_FETCH;
         wait_cnt <= '0;
         op_q     <= '0;
         funct_q  <= '0;
      end else begin
         if (waiting && !MemReady && !timeout) wait_cnt <= wait_cnt + CNT_W'(1);
         else                                  wait_cnt <= '0;
         case (state)
            S_FETCH:
               if (MemReady) begin
                  op_q    <= Opcode;
                  funct_q <= FuncCode;
                  state   <= S_DECODE;
               end else if (timeout) begin
                  state <= S_FETCH;
               end
            S_DECODE:
               if (!legal)              state <= S_ERR;
               else if (is_j || is_jal) state <= S_FETCH;
               else                     state <= S_EXEC;
            S_EXEC:
               if (is_beq)              state <= S_FETCH;
               else if (is_lw || is_sw) state <= S_MEM;
               else                     state <= S_WB;
            S_MEM:
               if (MemReady)     state <= is_lw ? S_WB : S_FETCH;
               else if (timeout) state <= S_FETCH;
            default: state <= S_FETCH;
         endcase
      end
   end

   // Strobes that complete a handshake (IRWrite, PCWrite on beq) follow
   // MemReady/Zero in the same cycle; everything else is a function of state.
   always_comb begin
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      RegDst     = DST_RT;
      ALUSrc1    = 1'b0;
      ALUSrc2    = SRC2_RT;
      MemToReg   = M2R_ALU;
      PCSource   = PCS_PC4;
      SignExtend = 1'b0;
      IorD       = 1'b0;
      ALUOp      = ALUOP_W'(ALU_ADD);
      Illegal    = 1'b0;
      MemError   = timeout;
      case (state)
         S_FETCH: begin
            MemRead = !timeout;
            ALUSrc2 = SRC2_FOUR;
            if (MemReady) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
            end
         end
         S_DECODE: begin
            ALUSrc2    = SRC2_IMM;
            SignExtend = 1'b1;
            if (legal && (is_j || is_jal)) begin
               PCWrite  = 1'b1;
               PCSource = PCS_JMP;
            end
            if (legal && is_jal) begin
               RegWrite = 1'b1;
               RegDst   = DST_RA;
               MemToReg = M2R_PC4;
            end
         end
         S_EXEC, S_MEM, S_WB: begin
            ALUOp      = dec_alu_ext;
            ALUSrc1    = dec_src1;
            SignExtend = dec_sext;
            ALUSrc2    = (is_rtype || is_beq) ? SRC2_RT : SRC2_IMM;
            if (state == S_EXEC && is_beq) begin
               PCWrite  = Zero;
               PCSource = PCS_BR;
            end
            if (state == S_MEM) begin
               IorD     = 1'b1;
               MemRead  = is_lw && !timeout;
               MemWrite = is_sw && !timeout;
            end
            if (state == S_WB) begin
               RegWrite = 1'b1;
               RegDst   = is_rtype ? DST_RD : DST_RT;
               MemToReg = is_lw ? M2R_MEM : M2R_ALU;
            end
         end
         S_ERR: Illegal = 1'b1;
         default: ;
      endcase
      // Held reset keeps the datapath quiet, so an aborted instruction never writes.
      if (!Reset_L) begin
         PCWrite  = 1'b0;
         IRWrite  = 1'b0;
         MemRead  = 1'b0;
         MemWrite = 1'b0;
         RegWrite = 1'b0;
         Illegal  = 1'b0;
         MemError = 1'b0;
      end
   end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: per-cycle state scoreboard plus
// spot checks of the control outputs for each instruction class.
module tb_multi_cycle_control;
   import mips_ctrl_pkg::*;

   logic       CLK = 1'b0;
   logic       Reset_L;
   logic [5:0] Opcode, FuncCode;
   logic       MemReady, Zero;

   logic       PCWrite, IRWrite, MemRead, MemWrite, RegWrite;
   logic [1:0] RegDst, ALUSrc2, MemToReg, PCSource;
   logic       ALUSrc1, SignExtend, IorD, Illegal, MemError;
   logic [3:0] ALUOp;
   logic [2:0] State;

   logic       nj_PCWrite, nj_IRWrite, nj_MemRead, nj_MemWrite, nj_RegWrite;
   logic [1:0] nj_RegDst, nj_ALUSrc2, nj_MemToReg, nj_PCSource;
   logic       nj_ALUSrc1, nj_SignExtend, nj_IorD, nj_Illegal, nj_MemError;
   logic [3:0] nj_ALUOp;
   logic [2:0] nj_State;

   int         total = 0;
   int         passed = 0;
   int         fails = 0;
   int         regw_cnt = 0;
   logic [2:0] exp_q[$];

   // clock / reset
   always #5 CLK = ~CLK;

   multi_cycle_control dut (
      .CLK(CLK), .Reset_L(Reset_L), .Opcode(Opcode), .FuncCode(FuncCode),
      .MemReady(MemReady), .Zero(Zero),
      .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
      .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2),
      .MemToReg(MemToReg), .PCSource(PCSource), .SignExtend(SignExtend), .IorD(IorD),
      .ALUOp(ALUOp), .Illegal(Illegal), .MemError(MemError), .State(State)
   );

   multi_cycle_control #(.SUPPORT_JAL(0)) dut_nj (
      .CLK(CLK), .Reset_L(Reset_L), .Opcode(Opcode), .FuncCode(FuncCode),
      .MemReady(MemReady), .Zero(Zero),
      .PCWrite(nj_PCWrite), .IRWrite(nj_IRWrite), .MemRead(nj_MemRead),
      .MemWrite(nj_MemWrite), .RegWrite(nj_RegWrite), .RegDst(nj_RegDst),
      .ALUSrc1(nj_ALUSrc1), .ALUSrc2(nj_ALUSrc2), .MemToReg(nj_MemToReg),
      .PCSource(nj_PCSource), .SignExtend(nj_SignExtend), .IorD(nj_IorD),
      .ALUOp(nj_ALUOp), .Illegal(nj_Illegal), .MemError(nj_MemError), .State(nj_State)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [2:0] s);
      exp_q.push_back(s);
   endtask

   // driver: apply handshake inputs, then score State at mid-cycle
   task automatic mid(input logic mr, input logic z);
      MemReady = mr;
      Zero     = z;
      @(negedge CLK);
      regw_cnt += int'(RegWrite);
      if (exp_q.size() == 0) begin
         total++;
         fails++;
         $error("FAIL sb_underflow: observed state %0d expected none", State);
      end else begin
         chk("state", 32'(State), 32'(exp_q.pop_front()));
      end
   endtask

   task automatic next();
      @(posedge CLK);
      #1;
   endtask

   task automatic load(input logic [5:0] op, input logic [5:0] fn);
      Opcode   = op;
      FuncCode = fn;
   endtask

   initial begin
      Reset_L = 1'b0;
      MemReady = 1'b0;
      Zero = 1'b0;
      load(6'd0, 6'd0);
      repeat (2) @(posedge CLK);
      #1;
      @(negedge CLK);
      chk("rst_state", 32'(State), 32'(S_FETCH));
      chk("rst_memread", 32'(MemRead), 32'd0);
      chk("rst_irwrite", 32'(IRWrite), 32'd0);
      chk("rst_errs", 32'({Illegal, MemError}), 32'd0);
      next();
      Reset_L = 1'b1;

      // add $3,$1,$2
      load(OP_RTYPE, 6'b100000);
      push(S_FETCH); push(S_DECODE); push(S_EXEC); push(S_WB);
      mid(1, 0);
      chk("add_fetch_ir_pc", 32'({IRWrite, PCWrite, MemRead, IorD}), 32'b1110);
      chk("add_fetch_src2", 32'(ALUSrc2), 32'd2);
      next();
      load(6'b111111, 6'b111111);
      mid(1, 0);
      chk("add_dec_src2_sext", 32'({ALUSrc2, SignExtend, PCWrite}), 32'b0110);
      next();
      mid(1, 0);
      chk("add_exec_aluop", 32'(ALUOp), 32'hF);
      chk("add_exec_src2", 32'(ALUSrc2), 32'd0);
      next();
      mid(1, 0);
      chk("add_wb", 32'({RegWrite, RegDst, MemToReg}), 32'b10100);
      chk("add_wb_aluop", 32'(ALUOp), 32'hF);
      next();

      // lw with three MEM wait cycles
      load(OP_LW, 6'd0);
      regw_cnt = 0;
      push(S_FETCH); push(S_DECODE); push(S_EXEC);
      push(S_MEM); push(S_MEM); push(S_MEM); push(S_MEM); push(S_WB); push(S_FETCH);
      mid(1, 0); next();
      mid(1, 0); next();
      mid(1, 0);
      chk("lw_exec", 32'({ALUOp, ALUSrc2, SignExtend}), 32'b0010_01_1);
      next();
      for (int i = 0; i < 3; i++) begin
         mid(0, 0);
         chk("lw_mem_wait", 32'({MemRead, IorD, RegWrite, MemError}), 32'b1100);
         next();
      end
      mid(1, 0);
      chk("lw_mem_done", 32'({MemRead, IorD}), 32'b11);
      next();
      mid(1, 0);
      chk("lw_wb", 32'({RegWrite, MemToReg, RegDst}), 32'b10100);
      next();
      mid(0, 0);
      chk("lw_regwrite_pulses", 32'(regw_cnt), 32'd1);
      next();

      // beq taken, then not taken
      load(OP_BEQ, 6'd0);
      push(S_FETCH); push(S_DECODE); push(S_EXEC);
      mid(1, 0); next();
      mid(1, 0); next();
      mid(1, 1);
      chk("beq_taken", 32'({PCWrite, PCSource}), 32'b101);
      chk("beq_aluop", 32'(ALUOp), 32'(ALU_SUB));
      next();
      push(S_FETCH); push(S_DECODE); push(S_EXEC);
      mid(1, 1); next();
      mid(1, 1);
      chk("beq_dec_nowrite", 32'(PCWrite), 32'd0);
      next();
      mid(1, 0);
      chk("beq_not_taken", 32'({PCWrite, PCSource}), 32'b001);
      next();

      // sw, memory ready immediately
      load(OP_SW, 6'd0);
      push(S_FETCH); push(S_DECODE); push(S_EXEC); push(S_MEM);
      mid(1, 0); next();
      mid(1, 0); next();
      mid(1, 0); next();
      mid(1, 0);
      chk("sw_mem", 32'({MemWrite, MemRead, RegWrite, IorD}), 32'b1001);
      next();

      // ori: zero-extended immediate, rt destination
      load(OP_ORI, 6'd0);
      push(S_FETCH); push(S_DECODE); push(S_EXEC); push(S_WB);
      mid(1, 0); next();
      mid(1, 0); next();
      mid(1, 0);
      chk("ori_exec", 32'({ALUOp, SignExtend, ALUSrc2}), 32'b0001_0_01);
      next();
      mid(1, 0);
      chk("ori_wb", 32'({RegWrite, RegDst}), 32'b100);
      next();

      // sll: shamt feeds ALU input 1
      load(OP_RTYPE, FN_SLL);
      push(S_FETCH); push(S_DECODE); push(S_EXEC); push(S_WB);
      mid(1, 0); next();
      mid(1, 0); next();
      mid(1, 0);
      chk("sll_src1", 32'(ALUSrc1), 32'd1);
      next();
      mid(1, 0); next();

      // j: two-cycle jump
      load(OP_J, 6'd0);
      push(S_FETCH); push(S_DECODE);
      mid(1, 0); next();
      mid(1, 0);
      chk("j_decode", 32'({PCWrite, PCSource, RegWrite}), 32'b1100);
      next();

      // illegal opcode
      load(6'b111111, 6'd0);
      push(S_FETCH); push(S_DECODE); push(S_ERR);
      mid(1, 0); next();
      mid(1, 0);
      chk("ill_dec_quiet", 32'({Illegal, PCWrite, RegWrite}), 32'd0);
      next();
      mid(1, 0);
      chk("ill_err", 32'({Illegal, RegWrite, MemWrite, PCWrite}), 32'b1000);
      next();

      // fetch timeout: MemReady never arrives
      load(OP_RTYPE, 6'b100000);
      for (int k = 1; k <= 15; k++) begin
         push(S_FETCH);
         mid(0, 0);
         if (k == 1) chk("ill_back_fetch", 32'(Illegal), 32'd0);
         chk($sformatf("to_memerror_%0d", k), 32'(MemError), 32'(k == 15));
         chk($sformatf("to_memread_%0d", k), 32'(MemRead), 32'(k != 15));
         next();
      end
      // counter restarted: MemReady on the 15th wait cycle still wins
      for (int k = 1; k <= 14; k++) begin
         push(S_FETCH);
         mid(0, 0);
         chk($sformatf("to2_memerror_%0d", k), 32'(MemError), 32'd0);
         next();
      end
      push(S_FETCH); push(S_DECODE); push(S_EXEC); push(S_WB);
      mid(1, 0);
      chk("to_ready_wins", 32'({MemError, IRWrite}), 32'b01);
      next();
      mid(1, 0); next();
      mid(1, 0); next();
      mid(1, 0); next();

      // sw aborted by reset while waiting in MEM
      load(OP_SW, 6'd0);
      push(S_FETCH); push(S_DECODE); push(S_EXEC); push(S_MEM); push(S_MEM);
      mid(1, 0); next();
      mid(1, 0); next();
      mid(1, 0); next();
      mid(0, 0);
      chk("swr_mem_write", 32'(MemWrite), 32'd1);
      next();
      Reset_L = 1'b0;
      mid(0, 0);
      chk("swr_in_reset", 32'({MemWrite, RegWrite}), 32'd0);
      next();
      Reset_L = 1'b1;
      push(S_FETCH);
      mid(0, 0);
      chk("swr_after", 32'({MemWrite, RegWrite, MemRead}), 32'b001);
      next();

      // jal: legal on the default build, illegal when unsupported
      load(OP_JAL, 6'd0);
      push(S_FETCH); push(S_DECODE); push(S_FETCH);
      mid(1, 0); next();
      mid(1, 0);
      chk("jal_decode", 32'({PCWrite, PCSource, RegWrite, RegDst, MemToReg}), 32'b1_10_1_10_10);
      chk("nj_jal_decode_state", 32'(nj_State), 32'(S_DECODE));
      chk("nj_jal_nowrite", 32'({nj_RegWrite, nj_PCWrite}), 32'd0);
      next();
      mid(0, 0);
      chk("jal_no_illegal", 32'(Illegal), 32'd0);
      chk("nj_jal_err_state", 32'(nj_State), 32'(S_ERR));
      chk("nj_jal_illegal", 32'(nj_Illegal), 32'd1);
      next();

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
